// File: rtl/mlp_argmax_classifier_if.sv
// Score stream and classification result bundle for the last MLP stage.
// The producer/consumer side uses master; the classifier uses slave.
interface mlp_argmax_classifier_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_score;
  logic [IDX_W-1:0]  in_neuron;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_digit;
  logic [DATA_W-1:0] out_score;
  logic [DATA_W-1:0] out_margin;
  logic              out_err;

  modport master (
    output in_valid, in_score, in_neuron, out_ready,
    input  in_ready, out_valid, out_digit, out_score, out_margin, out_err
  );

  modport slave (
    input  in_valid, in_score, in_neuron, out_ready,
    output in_ready, out_valid, out_digit, out_score, out_margin, out_err
  );
endinterface

// File: rtl/mlp_argmax_classifier.sv
// Argmax over one frame of output-layer scores, reporting the winning digit,
// its score and the margin over the runner-up through a valid/ready result port.
module mlp_argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4
) (
  input logic                    clk,
  input logic                    reset,
  mlp_argmax_classifier_if.slave bus
);

  typedef enum logic {COLLECT, RESULT} stateT;

  localparam logic signed [DATA_W-1:0] MIN_SCORE = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_CLASSES - 1);

  stateT                    r_state;
  logic [IDX_W-1:0]         r_count;
  logic signed [DATA_W-1:0] r_best;
  logic signed [DATA_W-1:0] r_second;
  logic [IDX_W-1:0]         r_bestIdx;
  logic                     r_haveSecond;
  logic                     r_err;
  logic [IDX_W-1:0]         r_outDigit;
  logic [DATA_W-1:0]        r_outScore;
  logic [DATA_W-1:0]        r_outMargin;
  logic                     r_outErr;

  logic signed [DATA_W-1:0] w_score;
  logic signed [DATA_W-1:0] w_nextBest;
  logic signed [DATA_W-1:0] w_nextSecond;
  logic [IDX_W-1:0]         w_nextBestIdx;
  logic                     w_nextHaveSecond;
  logic                     w_nextErr;
  logic                     w_last;
  logic [DATA_W-1:0]        w_margin;

  assign w_score   = bus.in_score;
  assign w_last    = (r_count == LAST_IDX);
  assign w_nextErr = r_err | (bus.in_neuron != r_count);

  // Running top-two update for the beat on the bus; the class index is the
  // beat position, never the (possibly wrong) in_neuron value.
  always_comb begin
    w_nextBest       = r_best;
    w_nextSecond     = r_second;
    w_nextBestIdx    = r_bestIdx;
    w_nextHaveSecond = 1'b1;
    if (r_count == '0) begin
      w_nextBest       = w_score;
      w_nextBestIdx    = '0;
      w_nextSecond     = MIN_SCORE;
      w_nextHaveSecond = 1'b0;
    end else if (w_score > r_best) begin
      w_nextSecond  = r_best;
      w_nextBest    = w_score;
      w_nextBestIdx = r_count;
    end else if ((w_score > r_second) || !r_haveSecond) begin
      w_nextSecond = w_score;
    end
  end

  // best >= second always, so the low DATA_W bits of the wide difference
  // equal a plain DATA_W-bit subtraction.
  assign w_margin = (NUM_CLASSES == 1) ? '0 : DATA_W'(w_nextBest - w_nextSecond);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= COLLECT;
      r_count      <= '0;
      r_best       <= '0;
      r_second     <= '0;
      r_bestIdx    <= '0;
      r_haveSecond <= 1'b0;
      r_err        <= 1'b0;
      r_outDigit   <= '0;
      r_outScore   <= '0;
      r_outMargin  <= '0;
      r_outErr     <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (bus.in_valid) begin
            r_best       <= w_nextBest;
            r_second     <= w_nextSecond;
            r_bestIdx    <= w_nextBestIdx;
            r_haveSecond <= w_nextHaveSecond;
            r_err        <= w_nextErr;
            if (w_last) begin
              r_state     <= RESULT;
              r_count     <= '0;
              r_outDigit  <= w_nextBestIdx;
              r_outScore  <= w_nextBest;
              r_outMargin <= w_margin;
              r_outErr    <= w_nextErr;
            end else begin
              r_count <= r_count + IDX_W'(1);
            end
          end
        end
        RESULT: begin
          if (bus.out_ready) begin
            r_state <= COLLECT;
            r_count <= '0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == COLLECT) && !reset;
  assign bus.out_valid  = (r_state == RESULT) && !reset;
  assign bus.out_digit  = r_outDigit;
  assign bus.out_score  = r_outScore;
  assign bus.out_margin = r_outMargin;
  assign bus.out_err    = r_outErr;

endmodule

// File: tb/tb_mlp_argmax_classifier.sv
// Self-checking bench for mlp_argmax_classifier: directed frame table plus
// random frames scored by a sort-based reference model.
module tb_mlp_argmax_classifier;
  localparam int NC = 10;
  localparam int DW = 16;
  localparam int IW = 4;

  typedef struct packed {
    logic [NC-1:0][DW-1:0] score;
    logic [NC-1:0][IW-1:0] neuron;
    logic [IW-1:0]         expDigit;
    logic [DW-1:0]         expScore;
    logic [DW-1:0]         expMargin;
    logic                  expErr;
  } frameT;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mlp_argmax_classifier_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

  mlp_argmax_classifier #(.NUM_CLASSES(NC), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sort all scores, top two give score and margin; winner is the
  // lowest position holding the top score; error if any neuron tag is off.
  function automatic frameT refModel(input frameT f);
    frameT r;
    int    v[NC];
    int    t;
    int    digit;
    r = f;
    for (int k = 0; k < NC; k++) v[k] = int'($signed(f.score[k]));
    for (int i = 0; i < NC; i++)
      for (int j = 0; j < NC - 1 - i; j++)
        if (v[j] < v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    digit = 0;
    for (int k = NC - 1; k >= 0; k--)
      if (int'($signed(f.score[k])) == v[0]) digit = k;
    r.expDigit  = IW'(digit);
    r.expScore  = DW'(v[0]);
    r.expMargin = DW'(v[0] - v[1]);
    r.expErr    = 1'b0;
    for (int k = 0; k < NC; k++)
      if (f.neuron[k] != IW'(k)) r.expErr = 1'b1;
    return r;
  endfunction

  function automatic frameT randFrame();
    frameT f;
    int    mode;
    int    j;
    f = '0;
    mode = $urandom_range(0, 2);
    for (int k = 0; k < NC; k++) begin
      f.neuron[k] = IW'(k);
      case (mode)
        0:       f.score[k] = DW'($urandom);
        1:       f.score[k] = DW'($urandom_range(0, 3));
        default: f.score[k] = DW'(-int'($urandom_range(0, 600)));
      endcase
    end
    if ($urandom_range(0, 4) == 0) begin
      j = $urandom_range(0, NC - 1);
      f.neuron[j] = f.neuron[j] ^ IW'($urandom_range(1, 15));
    end
    return refModel(f);
  endfunction

  // Sends beats 0..lastBeat with random idle gaps, honouring in_ready.
  task automatic applyStimulus(input frameT f, input int maxGap, input int lastBeat);
    int guard;
    for (int k = 0; k <= lastBeat; k++) begin
      repeat ($urandom_range(0, maxGap)) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid  = 1'b1;
      bus.in_score  = f.score[k];
      bus.in_neuron = f.neuron[k];
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
        tick();
        guard++;
      end
      if (guard == 100) begin
        checkOutput("in_ready timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
      if (k == NC - 1) checkOutput("out_valid before last beat", 32'(bus.out_valid), 32'd0);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic checkResult(input frameT f, input string tag);
    checkOutput({tag, " out_valid"},  32'(bus.out_valid),  32'd1);
    checkOutput({tag, " in_ready"},   32'(bus.in_ready),   32'd0);
    checkOutput({tag, " out_digit"},  32'(bus.out_digit),  32'(f.expDigit));
    checkOutput({tag, " out_score"},  32'(bus.out_score),  32'(f.expScore));
    checkOutput({tag, " out_margin"}, 32'(bus.out_margin), 32'(f.expMargin));
    checkOutput({tag, " out_err"},    32'(bus.out_err),    32'(f.expErr));
  endtask

  // Holds the result for holdCycles with out_ready low, then handshakes it.
  task automatic drainResult(input frameT f, input int holdCycles, input string tag);
    bus.out_ready = 1'b0;
    for (int c = 0; c < holdCycles; c++) begin
      tick();
      checkResult(f, {tag, " hold"});
    end
    bus.out_ready = 1'b1;
    tick();
    checkOutput({tag, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, " in_ready after handshake"},  32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b0;
  endtask

  frameT tbl[5];
  frameT f;
  frameT g;

  initial begin
    for (int k = 0; k < NC; k++) begin
      tbl[0].score[k]  = DW'(16 * (k + 1));
      tbl[0].neuron[k] = IW'(k);
      tbl[1].score[k]  = (k == 3 || k == 7) ? 16'hFFF0 : 16'hFF00;
      tbl[1].neuron[k] = IW'(k);
      tbl[2].score[k]  = (k == 4) ? 16'h7FFF : 16'h8000;
      tbl[2].neuron[k] = IW'(k);
      tbl[3].score[k]  = (k == 6) ? 16'd100 : DW'(3 * k);
      tbl[3].neuron[k] = (k == 3) ? 4'd5 : IW'(k);
    end
    tbl[0].expDigit = 4'd9; tbl[0].expScore = 16'h00A0; tbl[0].expMargin = 16'h0010; tbl[0].expErr = 1'b0;
    tbl[1].expDigit = 4'd3; tbl[1].expScore = 16'hFFF0; tbl[1].expMargin = 16'h0000; tbl[1].expErr = 1'b0;
    tbl[2].expDigit = 4'd4; tbl[2].expScore = 16'h7FFF; tbl[2].expMargin = 16'hFFFF; tbl[2].expErr = 1'b0;
    tbl[3].expDigit = 4'd6; tbl[3].expScore = 16'h0064; tbl[3].expMargin = 16'h0049; tbl[3].expErr = 1'b1;
    tbl[4] = tbl[0];

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_score  = '0;
    bus.in_neuron = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    checkOutput("reset in_ready",   32'(bus.in_ready),   32'd0);
    checkOutput("reset out_valid",  32'(bus.out_valid),  32'd0);
    checkOutput("reset out_digit",  32'(bus.out_digit),  32'd0);
    checkOutput("reset out_score",  32'(bus.out_score),  32'd0);
    checkOutput("reset out_margin", 32'(bus.out_margin), 32'd0);
    checkOutput("reset out_err",    32'(bus.out_err),    32'd0);
    reset = 1'b0;
    #1;
    checkOutput("in_ready after reset", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      bus.out_ready = 1'b1;
      applyStimulus(tbl[i], 0, NC - 1);
      checkResult(tbl[i], $sformatf("table[%0d]", i));
      drainResult(tbl[i], 0, $sformatf("table[%0d]", i));
    end

    // Backpressure with the next frame's first beat pending during RESULT.
    f = randFrame();
    applyStimulus(f, 3, NC - 1);
    checkResult(f, "backpressure");
    bus.in_valid  = 1'b1;
    bus.in_score  = tbl[2].score[0];
    bus.in_neuron = tbl[2].neuron[0];
    drainResult(f, 5, "backpressure");
    applyStimulus(tbl[2], 0, NC - 1);
    checkResult(tbl[2], "after backpressure");
    drainResult(tbl[2], 1, "after backpressure");

    // Reset in the middle of a frame.
    g = '0;
    for (int k = 0; k < NC; k++) begin
      g.score[k]  = (k == 1) ? 16'h7000 : DW'(k);
      g.neuron[k] = IW'(k);
    end
    applyStimulus(g, 1, 5);
    reset = 1'b1;
    tick();
    checkOutput("midframe reset in_ready",  32'(bus.in_ready),  32'd0);
    checkOutput("midframe reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midframe reset out_digit", 32'(bus.out_digit), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("midframe reset in_ready release", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < NC; k++) begin
      g.score[k]  = (k == 2) ? 16'd500 : DW'(5 * k);
      g.neuron[k] = IW'(k);
    end
    g.expDigit = 4'd2; g.expScore = 16'd500; g.expMargin = 16'd455; g.expErr = 1'b0;
    applyStimulus(g, 2, NC - 1);
    checkResult(g, "post reset");
    drainResult(g, 0, "post reset");

    for (int i = 0; i < 30; i++) begin
      f = randFrame();
      applyStimulus(f, 2, NC - 1);
      checkResult(f, $sformatf("random[%0d]", i));
      drainResult(f, $urandom_range(0, 3), $sformatf("random[%0d]", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
